fmc_mst_if: RTL
===============

FMC_MST_IF -- requirements
Module: fmc_mst_if

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 12: FMC address bus width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 16: FMC data width, a multiple of 8.
REQ-003 SHALL have parameter C_DATA_LATENCY, default 2: FMC_CLK cycles between the address phase and the data phase, range 0..15.
REQ-004 SHALL have parameter C_WAIT_TIMEOUT, default 255: maximum number of data-phase FMC_CLK cycles with FMC_NWAIT low.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; one clock, reset asynchronous active-low.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  C_ADDR_WIDTH  word address.
- cmd_wdata  in  C_DATA_WIDTH  write data.
- cmd_be  in  C_DATA_WIDTH/8  byte enables, active-high.
- rsp_valid  out  1  one-clk completion pulse.
- rsp_rdata  out  C_DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  wait timeout, qualified by rsp_valid.
- FMC_CLK  out  1  bus clock = clk/2.
- FMC_A  out  C_ADDR_WIDTH  address.
- FMC_D_I  in  C_DATA_WIDTH  read data from pad.
- FMC_D_O  out  C_DATA_WIDTH  write data to pad.
- FMC_D_T  out  C_DATA_WIDTH  per-bit tristate; 1 = pad is input.
- FMC_NBL  out  C_DATA_WIDTH/8  byte lanes, active-low.
- FMC_NE, FMC_NL, FMC_NOE, FMC_NWE  out  1 each  chip enable, address valid, output enable, write enable; all active-low.
- FMC_NWAIT  in  1  slave wait request, active-low.

Function
REQ-006 SHALL toggle FMC_CLK on every clk edge after reset; "fall slot" = the clk edge driving FMC_CLK 1->0, "rise slot" = the edge driving it 0->1.
REQ-007 SHALL update all FMC outputs only in fall slots, and SHALL sample FMC_D_I and FMC_NWAIT only in rise slots.
REQ-008 SHALL assert cmd_ready only in IDLE, registered, and SHALL latch the command on cmd_valid&&cmd_ready; cmd_valid SHALL be ignored while cmd_ready is low.
REQ-009 SHALL sequence states IDLE -> ADDR -> LAT -> DATA -> TURN -> IDLE, with ADDR entered at the first fall slot after acceptance.
REQ-010 ADDR SHALL last 1 FMC_CLK cycle with FMC_NE=0, FMC_NL=0, FMC_A=addr, FMC_NBL=~be, and FMC_NWE=cmd_rnw.
REQ-011 LAT SHALL last C_DATA_LATENCY FMC_CLK cycles with FMC_NL=1 and the other signals held; if C_DATA_LATENCY=0, LAT SHALL be skipped.
REQ-012 On a DATA write, SHALL drive FMC_D_O=wdata and FMC_D_T=all 0; on a DATA read, SHALL drive FMC_NOE=0 and FMC_D_T=all 1.
REQ-013 DATA SHALL complete in the first rise slot that samples FMC_NWAIT=1; reads SHALL capture FMC_D_I in that slot.
REQ-014 Each rise slot in DATA that samples FMC_NWAIT=0 SHALL increment a wait counter; on reaching C_WAIT_TIMEOUT, DATA SHALL terminate with rsp_err=1 and rsp_rdata=0.
REQ-015 TURN SHALL last 1 FMC_CLK cycle with FMC_NE, FMC_NOE and FMC_NWE at 1 and FMC_D_T=all 1.
REQ-016 SHALL pulse rsp_valid for exactly 1 clk at TURN entry, with rsp_rdata and rsp_err valid in the same cycle.
REQ-017 Unloaded transaction length SHALL be (3+C_DATA_LATENCY) FMC_CLK cycles, with FMC_NE low for (2+C_DATA_LATENCY) of them.
REQ-018 The earliest next acceptance SHALL be the clk after TURN ends; at most one transaction SHALL be outstanding.

Reset
REQ-019 While rst_n=0, outputs SHALL be immediately: FMC_CLK=0, FMC_NE=FMC_NL=FMC_NOE=FMC_NWE=1, FMC_NBL=all 1, FMC_A=0, FMC_D_O=0, FMC_D_T=all 1, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counters=0.
REQ-020 Reset asserted mid-transaction SHALL abort it with no rsp_valid; cmd_ready SHALL rise on the first clk after release.

Structure
REQ-021 State encodings and the FMC idle-level constants SHALL reside in shared package fmc_pkg.
REQ-022 SHALL instantiate one sub-module, fmc_clk_gen, producing FMC_CLK and the rise/fall slot strobes.

Verification
REQ-023 The bench SHALL cover a write with addr 0x123, wdata 0xBEEF, be 2'b11, C_DATA_LATENCY=2, NWAIT=1: FMC_NE low 4 FMC_CLK cycles, FMC_D_O=0xBEEF with FMC_D_T=0 in DATA, rsp_err=0.
REQ-024 The bench SHALL cover a read where the slave model returns 0x5A5A: FMC_NOE low 1 FMC_CLK cycle, rsp_rdata=0x5A5A.
REQ-025 The bench SHALL cover FMC_NWAIT low for 3 rise slots in DATA: DATA extended by exactly 3 FMC_CLK cycles, rsp_err=0.
REQ-026 The bench SHALL cover C_WAIT_TIMEOUT=8 with FMC_NWAIT stuck low: rsp_err=1 after 8 wait cycles, bus released in TURN.
REQ-027 The bench SHALL cover a write with be 2'b01: FMC_NBL=2'b10 through ADDR, LAT and DATA.
REQ-028 The bench SHALL cover rst_n pulsed low during LAT: all outputs idle immediately, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/fmc_pkg.sv
// Shared FMC master definitions: controller state encoding and bus idle levels.
package fmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LAT,
        ST_DATA,
        ST_TURN
    } fmc_state_t;

    localparam logic FMC_CTL_IDLE  = 1'b1;  // NE/NL/NOE/NWE inactive level
    localparam logic FMC_CLK_RESET = 1'b0;
    localparam logic FMC_DT_INPUT  = 1'b1;  // pad direction when not driving

endpackage

// File: rtl/fmc_clk_gen.sv
// FMC bus clock at clk/2 plus strobes marking which clk edge comes next.
module fmc_clk_gen
    import fmc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic fmc_clk,
    output logic rise_slot,
    output logic fall_slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fmc_clk <= FMC_CLK_RESET;
        else        fmc_clk <= ~fmc_clk;
    end

    // The coming edge drives FMC_CLK high when it is currently low, and vice versa.
    always_comb begin
        rise_slot = ~fmc_clk;
        fall_slot = fmc_clk;
    end

endmodule

// File: rtl/fmc_mst_if.sv
// Single-outstanding FMC bus master: multiplexed address phase, fixed latency,
// NWAIT-extended data phase with timeout, one-cycle turnaround.
module fmc_mst_if
    import fmc_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH   = 12,
    parameter int unsigned C_DATA_WIDTH   = 16,
    parameter int unsigned C_DATA_LATENCY = 2,
    parameter int unsigned C_WAIT_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_be,
    output logic                      rsp_valid,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                      rsp_err,
    output logic                      FMC_CLK,
    output logic [C_ADDR_WIDTH-1:0]   FMC_A,
    input  logic [C_DATA_WIDTH-1:0]   FMC_D_I,
    output logic [C_DATA_WIDTH-1:0]   FMC_D_O,
    output logic [C_DATA_WIDTH-1:0]   FMC_D_T,
    output logic [C_DATA_WIDTH/8-1:0] FMC_NBL,
    output logic                      FMC_NE,
    output logic                      FMC_NL,
    output logic                      FMC_NOE,
    output logic                      FMC_NWE,
    input  logic                      FMC_NWAIT
);

    localparam int unsigned BE_W      = C_DATA_WIDTH / 8;
    localparam int unsigned WAIT_W    = $clog2(C_WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(C_WAIT_TIMEOUT - 1);
    localparam logic [3:0]        LAT_INIT  = 4'(C_DATA_LATENCY - 1);

    logic rise_slot, fall_slot;

    fmc_clk_gen u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .fmc_clk   (FMC_CLK),
        .rise_slot (rise_slot),
        .fall_slot (fall_slot)
    );

    fmc_state_t              state_q, state_d;
    logic                    pend_q, pend_d, ready_q, ready_d;
    logic                    rnw_q, rnw_d, done_q, done_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d, a_q, a_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d, do_q, do_d, dt_q, dt_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BE_W-1:0]         be_q, be_d, nbl_q, nbl_d;
    logic [3:0]              lat_q, lat_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic                    ne_q, ne_d, nl_q, nl_d, noe_q, noe_d, nwe_q, nwe_d;
    logic                    go_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            rnw_q       <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            lat_q       <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            a_q         <= '0;
            do_q        <= '0;
            dt_q        <= {C_DATA_WIDTH{FMC_DT_INPUT}};
            nbl_q       <= '1;
            ne_q        <= FMC_CTL_IDLE;
            nl_q        <= FMC_CTL_IDLE;
            noe_q       <= FMC_CTL_IDLE;
            nwe_q       <= FMC_CTL_IDLE;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            rnw_q       <= rnw_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            lat_q       <= lat_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            a_q         <= a_d;
            do_q        <= do_d;
            dt_q        <= dt_d;
            nbl_q       <= nbl_d;
            ne_q        <= ne_d;
            nl_q        <= nl_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ready_d     = ready_q;
        rnw_d       = rnw_q;
        done_d      = done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        lat_d       = lat_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        a_d         = a_q;
        do_d        = do_q;
        dt_d        = dt_q;
        nbl_d       = nbl_q;
        ne_d        = ne_q;
        nl_d        = nl_q;
        noe_d       = noe_q;
        nwe_d       = nwe_q;
        go_data     = 1'b0;

        case (state_q)
            // Accepted command waits in pend until the next fall slot starts ADDR.
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    rnw_d   = cmd_rnw;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
                    pend_d  = 1'b1;
                    ready_d = 1'b0;
                end else if (pend_q) begin
                    if (fall_slot) begin
                        state_d = ST_ADDR;
                        pend_d  = 1'b0;
                        ne_d    = 1'b0;
                        nl_d    = 1'b0;
                        a_d     = addr_q;
                        nbl_d   = ~be_q;
                        nwe_d   = rnw_q;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (fall_slot) begin
                    nl_d = FMC_CTL_IDLE;
                    if (C_DATA_LATENCY == 0) begin
                        go_data = 1'b1;
                    end else begin
                        state_d = ST_LAT;
                        lat_d   = LAT_INIT;
                    end
                end
            end
            ST_LAT: begin
                if (fall_slot) begin
                    if (lat_q == '0) go_data = 1'b1;
                    else             lat_d   = lat_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (rise_slot && !done_q) begin
                    if (FMC_NWAIT) begin
                        done_d  = 1'b1;
                        rdata_d = rnw_q ? FMC_D_I : '0;
                        err_d   = 1'b0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                        if (wait_q == WAIT_LAST) begin
                            done_d  = 1'b1;
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end else if (fall_slot && done_q) begin
                    state_d     = ST_TURN;
                    rsp_valid_d = 1'b1;
                    ne_d        = FMC_CTL_IDLE;
                    nl_d        = FMC_CTL_IDLE;
                    noe_d       = FMC_CTL_IDLE;
                    nwe_d       = FMC_CTL_IDLE;
                    nbl_d       = '1;
                    dt_d        = {C_DATA_WIDTH{FMC_DT_INPUT}};
                end
            end
            ST_TURN: begin
                if (fall_slot) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared by ADDR (zero latency) and LAT exits.
        if (go_data) begin
            state_d = ST_DATA;
            wait_d  = '0;
            done_d  = 1'b0;
            if (rnw_q) begin
                noe_d = 1'b0;
                dt_d  = {C_DATA_WIDTH{FMC_DT_INPUT}};
            end else begin
                do_d = wdata_q;
                dt_d = '0;
            end
        end
    end

    always_comb begin
        cmd_ready = ready_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        FMC_A     = a_q;
        FMC_D_O   = do_q;
        FMC_D_T   = dt_q;
        FMC_NBL   = nbl_q;
        FMC_NE    = ne_q;
        FMC_NL    = nl_q;
        FMC_NOE   = noe_q;
        FMC_NWE   = nwe_q;
    end

endmodule
